// File: rtl/muldiv_ctl_pkg.sv
// muldiv_ctl_pkg: shared types for the iterative RV32M multiply/divide unit.
// Holds the funct3 op encoding, FSM states and small op classifiers.
package muldiv_ctl_pkg;

    localparam int MdWidth = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } rvga_muldiv_op;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } rvga_muldiv_state;

    function automatic logic op_is_div(rvga_muldiv_op op);
        return op[2];
    endfunction

    function automatic logic op_rs1_signed(rvga_muldiv_op op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic op_rs2_signed(rvga_muldiv_op op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/dff.sv
// dff: enabled register with synchronous active-low clear.
// Ports: clk_i, rst_i (0 = clear), en_i, d_i, q_o.
module dff #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/muldiv_ctl_dp.sv
// muldiv_dp: radix-2 shift/add multiply and restoring divide datapath.
// Ports: load/step strobes, op + operands in; sign-fixed result and fast-path result out.
module muldiv_dp
    import muldiv_ctl_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [2:0]         funct3_i,
    input  logic [width_p-1:0] rs1_i,
    input  logic [width_p-1:0] rs2_i,
    output logic               spec_o,
    output logic [width_p-1:0] spec_res_o,
    output logic [width_p-1:0] fix_res_o
);

    rvga_muldiv_op      op_in;
    rvga_muldiv_op      op_q, op_d;
    logic [width_p-1:0] a_q, a_d;
    logic [width_p-1:0] hi_q, hi_d;
    logic [width_p-1:0] lo_q, lo_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;

    logic               s1, s2;
    logic [width_p-1:0] mag1, mag2;
    logic [width_p-1:0] addend;
    logic [width_p:0]   mul_sum;
    logic [width_p:0]   rem_sh;
    logic [width_p:0]   diff;
    logic [2*width_p-1:0] prod, prod_s;
    logic [width_p-1:0] quo_s, rem_s;
    logic               div_zero, div_ovf;

    assign op_in = rvga_muldiv_op'(funct3_i);
    assign s1    = op_rs1_signed(op_in) & rs1_i[width_p-1];
    assign s2    = op_rs2_signed(op_in) & rs2_i[width_p-1];
    assign mag1  = s1 ? -rs1_i : rs1_i;
    assign mag2  = s2 ? -rs2_i : rs2_i;

    // Multiply: {hi,lo} shifts right, lo starts as multiplier.
    assign addend  = lo_q[0] ? a_q : '0;
    assign mul_sum = {1'b0, hi_q} + {1'b0, addend};

    // Divide: {hi,lo} shifts left, lo collects quotient bits.
    assign rem_sh = {hi_q, lo_q[width_p-1]};
    assign diff   = rem_sh - {1'b0, a_q};

    always_comb begin
        op_d   = op_q;
        a_d    = a_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        if (load_i) begin
            op_d   = op_in;
            a_d    = op_is_div(op_in) ? mag2 : mag1;
            lo_d   = op_is_div(op_in) ? mag1 : mag2;
            hi_d   = '0;
            neg_d  = s1 ^ s2;
            rneg_d = s1;
        end else if (step_i) begin
            if (op_is_div(op_q)) begin
                // Borrow in diff[msb] means restore (keep shifted value).
                hi_d = diff[width_p] ? rem_sh[width_p-1:0]
                                     : diff[width_p-1:0];
                lo_d = {lo_q[width_p-2:0], ~diff[width_p]};
            end else begin
                hi_d = mul_sum[width_p:1];
                lo_d = {mul_sum[0], lo_q[width_p-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            op_q   <= MD_MUL;
            a_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            a_q    <= a_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
        end
    end

    assign prod   = {hi_q, lo_q};
    assign prod_s = neg_q ? -prod : prod;
    assign quo_s  = neg_q ? -lo_q : lo_q;
    assign rem_s  = rneg_q ? -hi_q : hi_q;

    always_comb begin
        fix_res_o = rem_s;
        unique case (op_q)
            MD_MUL:                       fix_res_o = prod_s[width_p-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res_o = prod_s[2*width_p-1:width_p];
            MD_DIV, MD_DIVU:              fix_res_o = quo_s;
            MD_REM, MD_REMU:              fix_res_o = rem_s;
        endcase
    end

    // Cases resolved without iterating.
    assign div_zero = (rs2_i == '0);
    assign div_ovf  = ~funct3_i[0]
                    & (rs1_i == {1'b1, {(width_p-1){1'b0}}})
                    & (&rs2_i);
    assign spec_o   = funct3_i[2] & (div_zero | div_ovf);

    always_comb begin
        if (div_zero) begin
            spec_res_o = funct3_i[1] ? rs1_i : '1;
        end else begin
            spec_res_o = funct3_i[1] ? '0 : rs1_i;
        end
    end

endmodule

// File: rtl/muldiv_ctl.sv
// muldiv_ctl: FSM sequencing one RV32M op over width_p datapath steps.
// Ports: start/flush/funct3/operands in; busy stall, done pulse, registered result out.
module muldiv_ctl
    import muldiv_ctl_pkg::*;
#(
    parameter int width_p = MdWidth
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_v_i,
    input  logic               flush_v_i,
    input  logic [2:0]         funct3_i,
    input  logic [width_p-1:0] rs1_data_i,
    input  logic [width_p-1:0] rs2_data_i,
    output logic               busy_o,
    output logic               done_v_o,
    output logic [width_p-1:0] result_o
);

    localparam int CntW = (width_p > 1) ? $clog2(width_p) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(width_p - 1);

    rvga_muldiv_state   state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               load, step, busy, res_en;
    logic               spec;
    logic [width_p-1:0] spec_res, fix_res, res_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        res_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_v_i && !flush_v_i) begin
                    busy    = 1'b1;
                    load    = 1'b1;
                    cnt_d   = '0;
                    res_en  = spec;
                    state_d = spec ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_FIX: begin
                busy    = 1'b1;
                res_en  = ~flush_v_i;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush_v_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o   = busy;
    assign done_v_o = (state_q == ST_DONE);
    assign res_d    = load ? spec_res : fix_res;

    muldiv_dp #(
        .width_p(width_p)
    ) u_dp (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (load),
        .step_i    (step),
        .funct3_i  (funct3_i),
        .rs1_i     (rs1_data_i),
        .rs2_i     (rs2_data_i),
        .spec_o    (spec),
        .spec_res_o(spec_res),
        .fix_res_o (fix_res)
    );

    dff #(
        .width_p(width_p)
    ) u_res (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_i (res_en),
        .d_i  (res_d),
        .q_o  (result_o)
    );

endmodule

// File: tb/tb_muldiv_ctl.sv
// tb_muldiv_ctl: directed vectors and corner sequences for muldiv_ctl.
// Checks results, latency, busy/done timing, flush and reset behaviour.
module tb_muldiv_ctl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_v_i;
    logic        flush_v_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        busy_o;
    logic        done_v_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [19];

    always #5 clk = ~clk;

    muldiv_ctl #(.width_p(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_v_i (start_v_i),
        .flush_v_i (flush_v_i),
        .funct3_i  (funct3_i),
        .rs1_data_i(rs1_data_i),
        .rs2_data_i(rs2_data_i),
        .busy_o    (busy_o),
        .done_v_o  (done_v_o),
        .result_o  (result_o)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat,
                          input bit pulse);
        int cyc;
        bit bad;
        @(negedge clk);
        funct3_i   = f3;
        rs1_data_i = a;
        rs2_data_i = b;
        start_v_i  = 1'b1;
        #1 chk({nm, " busy_start"}, 32'(busy_o), 32'd1);
        @(negedge clk);
        start_v_i  = 1'b0;
        rs1_data_i = ~a;
        rs2_data_i = a ^ b;
        funct3_i   = ~f3;
        cyc = 1;
        bad = 1'b0;
        while (!done_v_o && cyc < 60) begin
            if (!busy_o) bad = 1'b1;
            @(negedge clk);
            cyc++;
            start_v_i = pulse && (cyc == 5 || cyc == 15);
        end
        start_v_i = 1'b0;
        chk({nm, " done"}, 32'(done_v_o), 32'd1);
        chk({nm, " latency"}, 32'(cyc), 32'(lat));
        chk({nm, " result"}, result_o, exp);
        chk({nm, " busy_calc"}, 32'(bad), 32'd0);
        chk({nm, " busy_done"}, 32'(busy_o), 32'd0);
        @(negedge clk);
        chk({nm, " done_pulse"}, 32'(done_v_o), 32'd0);
        chk({nm, " result_hold"}, result_o, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        34};
        vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         34};
        vecs[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[12] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        vecs[13] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
        vecs[14] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34};
        vecs[15] = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 34};
        vecs[16] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        vecs[17] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34};
        vecs[18] = '{3'b010, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 34};

        rst_i      = 1'b0;
        start_v_i  = 1'b0;
        flush_v_i  = 1'b0;
        funct3_i   = 3'b000;
        rs1_data_i = '0;
        rs2_data_i = '0;
        repeat (3) @(negedge clk);
        chk("reset result", result_o, 32'h0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset done", 32'(done_v_o), 32'd0);
        rst_i = 1'b1;

        for (int i = 0; i < 19; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a,
                   vecs[i].b, vecs[i].exp, vecs[i].lat, i == 0);
        end

        // Flush at cycle 10 of a divide, with a competing start.
        @(negedge clk);
        funct3_i   = 3'b100;
        rs1_data_i = 32'd1000;
        rs2_data_i = 32'd3;
        start_v_i  = 1'b1;
        @(negedge clk);
        start_v_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_v_i  = 1'b1;
        start_v_i  = 1'b1;
        funct3_i   = 3'b000;
        rs1_data_i = 32'd3;
        rs2_data_i = 32'd3;
        @(negedge clk);
        flush_v_i = 1'b0;
        start_v_i = 1'b0;
        #1;
        chk("flush busy", 32'(busy_o), 32'd0);
        chk("flush done", 32'(done_v_o), 32'd0);
        chk("flush result", result_o, 32'h0000_0001);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_v_o) ndone++;
        end
        chk("flush no_done", 32'(ndone), 32'd0);
        chk("flush result_after", result_o, 32'h0000_0001);
        run_op("post_flush", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b0);

        // Reset at cycle 20 of a multiply.
        @(negedge clk);
        funct3_i   = 3'b000;
        rs1_data_i = 32'd7;
        rs2_data_i = 32'hFFFF_FFFD;
        start_v_i  = 1'b1;
        @(negedge clk);
        start_v_i = 1'b0;
        repeat (19) @(negedge clk);
        chk("rst pre result", result_o, 32'd14);
        chk("rst pre busy", 32'(busy_o), 32'd1);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst mid result", result_o, 32'h0);
        chk("rst mid busy", 32'(busy_o), 32'd0);
        chk("rst mid done", 32'(done_v_o), 32'd0);
        rst_i = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_v_o || busy_o) ndone++;
        end
        chk("rst idle", 32'(ndone), 32'd0);
        run_op("post_rst", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 34, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctl.md
# muldiv_ctl

Iterative RV32M multiply/divide controller sitting beside the execute stage. It accepts one M-extension operation at a time, sequences a radix-2 shift/add-subtract datapath over `width_p` cycles, and holds the pipeline stalled via `busy_o` until the result is ready. Divide-by-zero and signed overflow are resolved in one cycle without iterating.

## Interface
- `width_p`, 32: operand/result width; iteration count equals `width_p`.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous and active-low (0 = reset).
- `start_v_i`  in  1  operation request; sampled only in IDLE.
- `flush_v_i`  in  1  abort in-flight operation.
- `funct3_i`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data_i`  in  `width_p`  dividend / multiplicand.
- `rs2_data_i`  in  `width_p`  divisor / multiplier.
- `busy_o`  out  1  stall request to pipeline stages (`stall_v_i`).
- `done_v_o`  out  1  one-cycle pulse; `result_o` valid.
- `result_o`  out  `width_p`  registered result; holds until next completion.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: on `start_v_i` latch `funct3_i`, operands, record sign flags, clear counter. Divide with rs2==0 or (signed DIV/REM, rs1==most-negative, rs2==all-ones) → DONE directly; otherwise → CALC.
- Signed ops convert operands to magnitudes at latch; MULHSU treats only rs1 as signed; unsigned ops take raw operands.
- CALC: one shift/add (multiply, 2·`width_p` product) or shift/subtract-restore (divide) step per cycle; counter increments; at counter == `width_p`-1 → FIX.
- FIX: apply sign correction (product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign); select low half (MUL), high half (MULH*), quotient or remainder; register into `result_o` → DONE.
- DONE: `done_v_o`=1 → IDLE next cycle.
- Special results: x/0 → quotient all-ones, remainder = rs1. Overflow → quotient = rs1 (0x8000_0000), remainder 0.
- `start_v_i` outside IDLE ignored.
- `flush_v_i` from any state → IDLE next cycle; no `done_v_o`, `result_o` unchanged; flush wins over simultaneous start.
- Reset (`rst_i`=0) any time, mid-operation included: state IDLE, counter 0, `result_o`=0, `done_v_o`=0, `busy_o`=0.

## Timing
- `busy_o` = (IDLE & `start_v_i` & ~`flush_v_i`) | CALC | FIX; combinational so the start cycle itself stalls. Low in DONE so stages advance and capture `result_o`.
- Normal latency: start sampled cycle 0 → CALC cycles 1..`width_p` → FIX cycle `width_p`+1 → DONE (`done_v_o`) cycle `width_p`+2 (34 for default).
- Fast path: start cycle 0 → DONE cycle 1.
- Back-to-back: next start accepted earliest in the IDLE cycle following DONE.
- Counter width `$clog2(width_p)`; no wrap beyond `width_p`-1.

## Structure
- Add to `rvga_types`: `rvga_muldiv_op` enum (funct3 encodings above), `rvga_muldiv_state` enum.
- Sub-module `muldiv_dp`: operand/accumulator registers, 2·`width_p` shifter, adder/subtractor, sign-correction negators; controlled by load/step/fix strobes from the FSM in `muldiv_ctl`.
- Reuse existing `dff` for `result_o` register.

## Test plan
- MUL 7 × 0xFFFF_FFFD (−3) → `result_o`=0xFFFF_FFEB, `done_v_o` exactly cycle 34, `busy_o` high cycles 0–33.
- MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE; MULH same operands → 0x0000_0000; MULHSU 0xFFFF_FFFF × 2 → 0xFFFF_FFFF.
- DIV −7 / 2 → 0xFFFF_FFFD; REM −7 / 2 → 0xFFFF_FFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIVU 5 / 0 → 0xFFFF_FFFF at cycle 1; REM 5 / 0 → 5; DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000, REM → 0, both cycle 1.
- Start DIV, assert `flush_v_i` at cycle 10 with `start_v_i` also high → IDLE at 11, no `done_v_o`, `result_o` unchanged; new start then completes normally.
- Drive `rst_i`=0 at cycle 20 of MUL → next cycle IDLE, `result_o`=0, `busy_o`=0; `start_v_i` pulses during CALC are ignored.
